// File: rtl/dstack_seq_pkg.sv
// rtl/dstack_seq_pkg.sv - shared types and constants for the data stack sequencer
package dstack_seq_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    PUSH  = 4'd1,
    DUP   = 4'd2,
    DROP  = 4'd3,
    DROP2 = 4'd4,
    ADD   = 4'd5,
    COPY  = 4'd6,
    ROT   = 4'd7,
    PUSH2 = 4'd8,
    DROP3 = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PHASE2 = 2'd1,
    FAULT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_OVER  = 2'b01,
    FLT_UNDER = 2'b10,
    FLT_IDX   = 2'b11
  } fault_t;

  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] MV_PUSH = 2'b01;
  localparam logic [1:0] MV_POP  = 2'b10;
  localparam logic [1:0] MV_POP2 = 2'b11;

endpackage

// File: rtl/dstack_seq_check.sv
// rtl/dstack_seq_check.sv - combinational legality check of one op against the depth shadow
module dstack_seq_check
  import dstack_seq_pkg::*;
#(
  parameter int DEPTH_MAG = 7,
  parameter int DEPTH     = 1 << DEPTH_MAG
) (
  input  logic [3:0]           op,
  input  logic [4:0]           idx,
  input  logic [DEPTH_MAG-1:0] depth,
  output logic                 ok,
  output fault_t               code
);

  // Wide enough for both the depth and the 5-bit index, plus headroom for DEPTH itself.
  localparam int CW = ((DEPTH_MAG > 5) ? DEPTH_MAG : 5) + 2;
  localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM2 = CW'(DEPTH - 2);

  logic [CW-1:0] d;
  logic [CW-1:0] n;
  logic          bad_idx;

  assign d       = CW'(depth);
  assign n       = CW'(idx);
  // Element 0 is the top itself, so a rotate/copy index must reach into the stored part.
  assign bad_idx = (n == '0) || (n > d);

  // Classify the op; a bad index wins over any depth problem.
  always_comb begin
    code = FLT_NONE;
    case (op)
      PUSH, DUP:  if (d >= LIM1)      code = FLT_OVER;
      PUSH2:      if (d >= LIM2)      code = FLT_OVER;
      DROP, ADD:  if (d < CW'(1))     code = FLT_UNDER;
      DROP2:      if (d < CW'(2))     code = FLT_UNDER;
      DROP3:      if (d < CW'(3))     code = FLT_UNDER;
      COPY: begin
        if (bad_idx)                  code = FLT_IDX;
        else if (d >= LIM1)           code = FLT_OVER;
      end
      ROT:        if (bad_idx)        code = FLT_IDX;
      default:    code = FLT_NONE;
    endcase
  end

  assign ok = (code == FLT_NONE);

endmodule

// File: rtl/dstack_seq.sv
// rtl/dstack_seq.sv - command sequencer driving the core0 data stack controls
module dstack_seq
  import dstack_seq_pkg::*;
#(
  parameter int DEPTH_MAG = 7,
  parameter int DEPTH     = 1 << DEPTH_MAG,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_imm,
  input  logic [WIDTH-1:0]     cmd_imm2,
  input  logic [4:0]           cmd_idx,
  output logic [1:0]           stk_movement,
  output logic [WIDTH-1:0]     stk_next_top,
  output logic                 stk_rotate,
  output logic [4:0]           stk_rot_addr,
  input  logic [WIDTH-1:0]     stk_top,
  input  logic [WIDTH-1:0]     stk_second,
  input  logic [WIDTH-1:0]     stk_third,
  input  logic [WIDTH-1:0]     stk_rot_val,
  output logic [DEPTH_MAG-1:0] depth,
  output logic                 fault,
  output logic [1:0]           fault_code,
  input  logic                 fault_ack
);

  state_t               state_q;
  logic [DEPTH_MAG-1:0] depth_q;
  logic [DEPTH_MAG-1:0] depth_nxt;
  logic [WIDTH-1:0]     imm2_q;
  logic                 ph_push_q;
  logic                 fault_q;
  fault_t               fault_code_q;
  logic                 chk_ok;
  fault_t               chk_code;
  logic                 go;

  dstack_seq_check #(
    .DEPTH_MAG (DEPTH_MAG),
    .DEPTH     (DEPTH)
  ) u_check (
    .op    (cmd_op),
    .idx   (cmd_idx),
    .depth (depth_q),
    .ok    (chk_ok),
    .code  (chk_code)
  );

  // Reset gates everything so an abandoned second step never reaches the stack.
  assign cmd_ready  = (state_q == IDLE) && !reset;
  assign go         = cmd_ready && cmd_valid && chk_ok;
  assign depth      = depth_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

  // Kept apart from next_top so the stack's rot_val lookup does not form a loop through one block.
  assign stk_rot_addr = (go && ((cmd_op == COPY) || (cmd_op == ROT))) ? cmd_idx : 5'd0;

  // Stack controls for the current step; holding stk_top is the idle behaviour.
  always_comb begin
    stk_movement = MV_NONE;
    stk_rotate   = 1'b0;
    stk_next_top = stk_top;
    if (go) begin
      case (cmd_op)
        PUSH, PUSH2: begin stk_movement = MV_PUSH; stk_next_top = cmd_imm; end
        DUP:         begin stk_movement = MV_PUSH; stk_next_top = stk_top; end
        DROP:        begin stk_movement = MV_POP;  stk_next_top = stk_second; end
        DROP2, DROP3: begin stk_movement = MV_POP2; stk_next_top = stk_third; end
        ADD:         begin stk_movement = MV_POP;  stk_next_top = stk_top + stk_second; end
        COPY:        begin stk_movement = MV_PUSH; stk_next_top = stk_rot_val; end
        ROT:         begin stk_rotate = 1'b1;      stk_next_top = stk_rot_val; end
        default:     stk_movement = MV_NONE;
      endcase
    end else if ((state_q == PHASE2) && !reset) begin
      if (ph_push_q) begin
        stk_movement = MV_PUSH;
        stk_next_top = imm2_q;
      end else begin
        stk_movement = MV_POP;
        stk_next_top = stk_second;
      end
    end
  end

  // Depth shadow follows exactly the movement presented to the stack.
  always_comb begin
    depth_nxt = depth_q;
    case (stk_movement)
      MV_PUSH: depth_nxt = depth_q + DEPTH_MAG'(1);
      MV_POP:  depth_nxt = depth_q - DEPTH_MAG'(1);
      MV_POP2: depth_nxt = depth_q - DEPTH_MAG'(2);
      default: depth_nxt = depth_q;
    endcase
  end

  // Sequencer FSM: accept, optional second step, or latch a fault until acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      depth_q      <= '0;
      imm2_q       <= '0;
      ph_push_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
    end else begin
      depth_q <= depth_nxt;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (!chk_ok) begin
              fault_q      <= 1'b1;
              fault_code_q <= chk_code;
              state_q      <= FAULT;
            end else if (cmd_op == PUSH2) begin
              imm2_q    <= cmd_imm2;
              ph_push_q <= 1'b1;
              state_q   <= PHASE2;
            end else if (cmd_op == DROP3) begin
              ph_push_q <= 1'b0;
              state_q   <= PHASE2;
            end
          end
        end
        PHASE2: state_q <= IDLE;
        FAULT: begin
          if (fault_ack) begin
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
